hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline stall and flush controller for the 5-stage core, covering the hazards that operand bypassing cannot. It inserts a one-cycle bubble on load-use dependencies and flushes IF/ID and ID/EX on taken branches resolved in EX. It also freezes EX across multi-cycle operations through a start/done handshake with the multi-cycle unit, with a watchdog timeout. It drives the PC, IF/ID and ID/EX write, flush and bubble controls.

## Interface
- MC_TIMEOUT, 64, maximum MC_BUSY cycles before fault (≥2)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_rs1, ID_rs2  in  5 each  ID-stage source register addresses
- ID_use_rs1, ID_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- EX_MemRead  in  1  EX instruction is a load
- EX_rd  in  5  EX destination register
- EX_branch_taken  in  1  branch/jump resolved taken in EX
- EX_mc_start  in  1  EX instruction is a multi-cycle op, first EX cycle
- mc_done  in  1  multi-cycle unit result valid, single-cycle pulse
- PC_Write  out  1  1 = PC updates
- IFID_Write  out  1  1 = IF/ID register loads
- IFID_Flush  out  1  1 = IF/ID loaded with NOP
- IDEX_Bubble  out  1  1 = ID/EX loaded with NOP
- EX_Hold  out  1  1 = ID/EX and EX-stage state frozen
- MEM_Bubble  out  1  1 = EX/MEM loaded with NOP
- mc_timeout  out  1  sticky fault flag
- stall_cycles  out  32  stall counter (macro-gated, see Configuration)

## Operation
- States: IDLE, MC_BUSY, FAULT. Reset state IDLE.
- load_use = EX_MemRead && EX_rd!=0 && ((ID_use_rs1 && EX_rd==ID_rs1) || (ID_use_rs2 && EX_rd==ID_rs2)).
- Outputs are combinational from state and current inputs. Defaults: PC_Write=1, IFID_Write=1, others 0.
- IDLE priority, highest first:
  - EX_branch_taken: IFID_Flush=1, IDEX_Bubble=1, PC_Write=1. Any load_use or EX_mc_start in the same cycle is ignored, and the state stays IDLE.
  - EX_mc_start: EX_Hold=1, MEM_Bubble=1, PC_Write=0, IFID_Write=0. Next state MC_BUSY, counter cleared to 0. mc_done is ignored in IDLE.
  - load_use: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, for exactly one cycle, since the load then advances.
- MC_BUSY:
  - mc_done=0: EX_Hold=1, MEM_Bubble=1, PC_Write=0, IFID_Write=0. Counter increments.
  - mc_done=1: defaults apply, so EX advances with the result. load_use is evaluated normally. Next state IDLE.
  - Counter == MC_TIMEOUT-1 with mc_done=0: next state FAULT. mc_done takes precedence in the same cycle.
  - Counter width is $clog2(MC_TIMEOUT).
- FAULT: PC_Write=0, IFID_Write=0, EX_Hold=1, MEM_Bubble=1, mc_timeout=1. Exit only via rst_n.
- EX_branch_taken and EX_mc_start are ignored outside IDLE.

## Timing
- While rst_n=0:
  - PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=1, EX_Hold=0, MEM_Bubble=0, mc_timeout=0, stall_cycles=0.
  - State forced to IDLE, counter forced to 0.
  - These values take effect immediately, regardless of clk.
- Zero-latency hazard response: controls are valid in the same cycle the hazard inputs are valid.
- Multi-cycle handshake: if mc_done arrives in the Nth MC_BUSY cycle, EX_Hold is high for N cycles (the start cycle plus N-1) and low in the mc_done cycle.
- Timeout: with no mc_done, there are MC_TIMEOUT MC_BUSY cycles, and mc_timeout rises on the following cycle.
- Reset mid-MC_BUSY abandons the operation. The multi-cycle unit is reset by the same rst_n.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - stall_cycles counts cycles with PC_Write=0 in IDLE or MC_BUSY; FAULT and reset are excluded.
  - The counter saturates at 32'hFFFF_FFFF and is cleared by rst_n.
- Not defined: stall_cycles port and its counter are absent.

## Test plan
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> one cycle PC_Write=0, IFID_Write=0, IDEX_Bubble=1. Next cycle EX_MemRead=0 -> defaults.
- No false stall: EX_rd=0 load with ID_rs1=0, and separately EX_rd=7 with ID_rs2=7 but ID_use_rs2=0 -> PC_Write=1, IDEX_Bubble=0 in both cases.
- Multi-cycle: EX_mc_start pulse, mc_done in the 4th MC_BUSY cycle -> EX_Hold and MEM_Bubble high for 4 cycles, low in the done cycle, state IDLE afterward. With the macro defined, stall_cycles=4.
- Simultaneous events: EX_branch_taken=1 with load_use=1 and EX_mc_start=1 -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, EX_Hold=0, state stays IDLE.
- Timeout: MC_TIMEOUT=8, start with no mc_done -> mc_timeout=1 on the cycle after the 8th MC_BUSY cycle, sticky. A late mc_done has no effect.
- Reset mid-MC_BUSY: rst_n low in the 3rd busy cycle -> immediately IDEX_Bubble=1, PC_Write=0, EX_Hold=0, stall_cycles=0. After release: state IDLE, defaults.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard control bundle between the pipeline and the stall unit.
// Carries ID/EX hazard inputs, the multi-cycle handshake and stage controls.
interface hazard_stall_unit_if;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic        EX_MemRead;
    logic [4:0]  EX_rd;
    logic        EX_branch_taken;
    logic        EX_mc_start;
    logic        mc_done;
    logic        PC_Write;
    logic        IFID_Write;
    logic        IFID_Flush;
    logic        IDEX_Bubble;
    logic        EX_Hold;
    logic        MEM_Bubble;
    logic        mc_timeout;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
        output EX_MemRead, EX_rd, EX_branch_taken,
        output EX_mc_start, mc_done,
        input  PC_Write, IFID_Write, IFID_Flush,
        input  IDEX_Bubble, EX_Hold, MEM_Bubble, mc_timeout
`ifdef HAZARD_STALL_CNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
        input  EX_MemRead, EX_rd, EX_branch_taken,
        input  EX_mc_start, mc_done,
        output PC_Write, IFID_Write, IFID_Flush,
        output IDEX_Bubble, EX_Hold, MEM_Bubble, mc_timeout
`ifdef HAZARD_STALL_CNT_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use bubble, branch flush, multi-cycle freeze
// with watchdog. Ports: clk, rst_n (async low), hz (hazard_stall_unit_if.slave).
// Optional macro HAZARD_STALL_CNT_EN adds the saturating hz.stall_cycles counter.
module hazard_stall_unit #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_unit_if.slave   hz
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_BUSY = 2'd1,
        FAULT   = 2'd2
    } state_e;

    localparam int CW = $clog2(MC_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(MC_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic load_use;
    logic pc_write, ifid_write, ifid_flush;
    logic idex_bubble, ex_hold, mem_bubble, timeout;

    always_comb begin
        load_use = hz.EX_MemRead && (hz.EX_rd != 5'd0) &&
                   ((hz.ID_use_rs1 && (hz.EX_rd == hz.ID_rs1)) ||
                    (hz.ID_use_rs2 && (hz.EX_rd == hz.ID_rs2)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        mem_bubble  = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.EX_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hz.EX_mc_start) begin
                    ex_hold    = 1'b1;
                    mem_bubble = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    state_d    = MC_BUSY;
                    cnt_d      = '0;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MC_BUSY: begin
                if (hz.mc_done) begin
                    // Result lands this cycle; EX advances normally.
                    state_d = IDLE;
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end else begin
                    ex_hold    = 1'b1;
                    mem_bubble = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ex_hold    = 1'b1;
                mem_bubble = 1'b1;
                timeout    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset overrides the outputs immediately, independent of clk.
    always_comb begin
        if (!rst_n) begin
            hz.PC_Write    = 1'b0;
            hz.IFID_Write  = 1'b0;
            hz.IFID_Flush  = 1'b0;
            hz.IDEX_Bubble = 1'b1;
            hz.EX_Hold     = 1'b0;
            hz.MEM_Bubble  = 1'b0;
            hz.mc_timeout  = 1'b0;
        end else begin
            hz.PC_Write    = pc_write;
            hz.IFID_Write  = ifid_write;
            hz.IFID_Flush  = ifid_flush;
            hz.IDEX_Bubble = idex_bubble;
            hz.EX_Hold     = ex_hold;
            hz.MEM_Bubble  = mem_bubble;
            hz.mc_timeout  = timeout;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Fault cycles are not stalls worth counting; saturate instead of wrap.
    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (state_q != FAULT) &&
            (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign hz.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit with MC_TIMEOUT=8.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    hazard_stall_unit_if hz();

    hazard_stall_unit #(.MC_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, MEM_Bubble, mc_timeout}
    logic [6:0]  exp_q[$];
    logic [31:0] stl_q[$];
    string       nam_q[$];

    localparam logic [6:0] E_RST  = 7'b0001000;
    localparam logic [6:0] E_DEF  = 7'b1100000;
    localparam logic [6:0] E_LU   = 7'b0001000;
    localparam logic [6:0] E_BR   = 7'b1111000;
    localparam logic [6:0] E_HOLD = 7'b0000110;
    localparam logic [6:0] E_FLT  = 7'b0000111;

    task automatic step(
        input logic        rst,
        input logic        br,
        input logic        ms,
        input logic        md,
        input logic        mr,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic        u1,
        input logic [4:0]  rs2,
        input logic        u2,
        input logic [6:0]  e,
        input logic [31:0] s,
        input string       n
    );
        @(posedge clk);
        #1;
        rst_n              = rst;
        hz.EX_branch_taken = br;
        hz.EX_mc_start     = ms;
        hz.mc_done         = md;
        hz.EX_MemRead      = mr;
        hz.EX_rd           = rd;
        hz.ID_rs1          = rs1;
        hz.ID_use_rs1      = u1;
        hz.ID_rs2          = rs2;
        hz.ID_use_rs2      = u2;
        exp_q.push_back(e);
        stl_q.push_back(s);
        nam_q.push_back(n);
    endtask

    task automatic idle(input logic [6:0] e, input logic [31:0] s,
                        input string n);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, s, n);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [6:0]  e;
            logic [6:0]  g;
            logic [31:0] s;
            string       n;
            e = exp_q.pop_front();
            s = stl_q.pop_front();
            n = nam_q.pop_front();
            g = {hz.PC_Write, hz.IFID_Write, hz.IFID_Flush,
                 hz.IDEX_Bubble, hz.EX_Hold, hz.MEM_Bubble,
                 hz.mc_timeout};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: ctrl got %b expected %b", n, g, e);
            end
`ifdef HAZARD_STALL_CNT_EN
            checks++;
            if (hz.stall_cycles !== s) begin
                errors++;
                $display("FAIL %s: stall_cycles got %0d expected %0d",
                         n, hz.stall_cycles, s);
            end
`else
            if (s === 32'hx) errors++;
`endif
        end
    end

    initial begin
        hz.EX_branch_taken = 0;
        hz.EX_mc_start     = 0;
        hz.mc_done         = 0;
        hz.EX_MemRead      = 0;
        hz.EX_rd           = 0;
        hz.ID_rs1          = 0;
        hz.ID_use_rs1      = 0;
        hz.ID_rs2          = 0;
        hz.ID_use_rs2      = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 0, "reset");
        idle(E_DEF, 0, "idle");
        step(1, 0, 0, 0, 1, 5, 5, 1, 0, 0, E_LU, 0, "load_use_rs1");
        idle(E_DEF, 1, "after_load_use");
        step(1, 0, 0, 0, 1, 9, 0, 0, 9, 1, E_LU, 1, "load_use_rs2");
        step(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, E_DEF, 2, "no_stall_x0");
        step(1, 0, 0, 0, 1, 7, 3, 1, 7, 0, E_DEF, 2, "no_stall_unused");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_BR, 2, "branch");
        step(1, 1, 1, 0, 1, 5, 5, 1, 0, 0, E_BR, 2, "simultaneous");
        idle(E_DEF, 2, "after_simultaneous");

        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_HOLD, 2, "mc_start");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_HOLD, 3, "busy1_br_ignored");
        idle(E_HOLD, 4, "busy2");
        idle(E_HOLD, 5, "busy3");
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_DEF, 6, "mc_done");
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_DEF, 6, "done_in_idle");

        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_HOLD, 6, "mc_start2");
        step(1, 0, 0, 1, 1, 4, 4, 1, 0, 0, E_LU, 7, "done_with_lu");
        idle(E_DEF, 8, "after_done_lu");

        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_HOLD, 8, "to_start");
        for (int k = 1; k <= 8; k++) begin
            idle(E_HOLD, 32'(8 + k), "to_busy");
        end
        idle(E_FLT, 17, "timeout");
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_FLT, 17, "late_done");
        step(1, 1, 1, 0, 1, 5, 5, 1, 0, 0, E_FLT, 17, "fault_sticky");

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 0, "reset_fault");
        idle(E_DEF, 0, "after_reset");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_HOLD, 0, "rst_start");
        idle(E_HOLD, 1, "rst_busy1");
        idle(E_HOLD, 2, "rst_busy2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 0, "rst_mid_busy");
        idle(E_DEF, 0, "post_rst");
        idle(E_DEF, 0, "post_rst_idle");

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
